// File: rtl/pipe_controller.sv
// ID-stage control unit: opcode decode, registered EX/MEM/WB control stages,
// load-use stall FSM and branch flush. Define CTRL_JUMP_EN for JAL/JALR/LUI/AUIPC.
module pipe_controller #(
  parameter int REG_ADDR_W       = 5,
  parameter int MUX_SEL_W        = 2,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [6:0]            opcode,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  ex_mem_re,
  output logic                  ex_mem_we,
  output logic                  ex_reg_write,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_illegal,
  output logic [1:0]            ex_alu_op,
  output logic [MUX_SEL_W-1:0]  ex_sel_mux_1,
  output logic [MUX_SEL_W-1:0]  ex_sel_mux_2,
  output logic [MUX_SEL_W-1:0]  ex_sel_mux_4,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_mem_re,
  output logic                  mem_mem_we,
  output logic                  mem_reg_write,
  output logic [MUX_SEL_W-1:0]  mem_sel_mux_2,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_reg_write,
  output logic [MUX_SEL_W-1:0]  wb_sel_mux_2,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [2:0]            state_dbg
);

  typedef enum logic {ST_RUN, ST_STALL} state_t;

  typedef struct packed {
    logic                 mem_re;
    logic                 mem_we;
    logic                 reg_write;
    logic                 branch;
    logic                 jump;
    logic                 illegal;
    logic [1:0]           alu_op;
    logic [MUX_SEL_W-1:0] mux1;
    logic [MUX_SEL_W-1:0] mux2;
    logic [MUX_SEL_W-1:0] mux4;
  } ctrl_t;

  state_t                state;
  logic [1:0]            cnt;
  ctrl_t                 dec, ex_c;
  logic                  use1, use2, legal, hazard;

  always_comb begin
    dec   = '0;
    use1  = 1'b0;
    use2  = 1'b0;
    legal = 1'b1;
    case (opcode)
      7'b0110011: begin
        dec.reg_write = 1'b1; dec.alu_op = 2'b10; dec.mux2 = MUX_SEL_W'(1);
        use1 = 1'b1; use2 = 1'b1;
      end
      7'b0010011: begin
        dec.reg_write = 1'b1; dec.alu_op = 2'b11;
        dec.mux1 = MUX_SEL_W'(1); dec.mux2 = MUX_SEL_W'(1);
        use1 = 1'b1;
      end
      7'b0000011: begin
        dec.mem_re = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b01;
        dec.mux1 = MUX_SEL_W'(1);
        use1 = 1'b1;
      end
      7'b0100011: begin
        dec.mem_we = 1'b1; dec.mux1 = MUX_SEL_W'(1); dec.mux4 = MUX_SEL_W'(1);
        use1 = 1'b1; use2 = 1'b1;
      end
      7'b1100011: begin
        dec.branch = 1'b1;
        use1 = 1'b1; use2 = 1'b1;
      end
`ifdef CTRL_JUMP_EN
      7'b1101111: begin
        dec.reg_write = 1'b1; dec.jump = 1'b1; dec.mux2 = MUX_SEL_W'(2);
      end
      7'b1100111: begin
        dec.reg_write = 1'b1; dec.jump = 1'b1;
        dec.mux1 = MUX_SEL_W'(1); dec.mux2 = MUX_SEL_W'(2);
        use1 = 1'b1;
      end
      7'b0110111: begin
        dec.reg_write = 1'b1; dec.mux2 = MUX_SEL_W'(3);
      end
      7'b0010111: begin
        dec.reg_write = 1'b1; dec.mux1 = MUX_SEL_W'(1);
        dec.mux4 = MUX_SEL_W'(2); dec.mux2 = MUX_SEL_W'(1);
      end
`endif
      default: legal = 1'b0;
    endcase
    if (rd == '0) dec.reg_write = 1'b0;
  end

  // Only a load sitting in EX can create a hazard; its result is not ready for ID.
  assign hazard = (LOAD_USE_BUBBLES != 0) && id_valid && ex_c.mem_re && (ex_rd != '0) &&
                  ((use1 && (rs1 == ex_rd)) || (use2 && (rs2 == ex_rd)));

  assign stall = !reset && !branch_taken && ((state == ST_STALL) || hazard);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_RUN;
      cnt           <= 2'd0;
      ex_c          <= '0;
      ex_rd         <= '0;
      mem_mem_re    <= 1'b0;
      mem_mem_we    <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_sel_mux_2 <= '0;
      mem_rd        <= '0;
      wb_reg_write  <= 1'b0;
      wb_sel_mux_2  <= '0;
      wb_rd         <= '0;
    end else begin
      mem_mem_re    <= ex_c.mem_re;
      mem_mem_we    <= ex_c.mem_we;
      mem_reg_write <= ex_c.reg_write;
      mem_sel_mux_2 <= ex_c.mux2;
      mem_rd        <= ex_rd;
      wb_reg_write  <= mem_reg_write;
      wb_sel_mux_2  <= mem_sel_mux_2;
      wb_rd         <= mem_rd;
      ex_c          <= '0;
      ex_rd         <= '0;
      if (branch_taken) begin
        state <= ST_RUN;
        cnt   <= 2'd0;
      end else begin
        case (state)
          ST_RUN: begin
            if (hazard) begin
              if (LOAD_USE_BUBBLES > 1) begin
                state <= ST_STALL;
                cnt   <= 2'(LOAD_USE_BUBBLES - 1);
              end
            end else if (id_valid && legal) begin
              ex_c  <= dec;
              ex_rd <= rd;
            end else if (id_valid) begin
              ex_c.illegal <= 1'b1;
            end
          end
          ST_STALL: begin
            cnt <= cnt - 2'd1;
            if (cnt == 2'd1) state <= ST_RUN;
          end
          default: begin
            state <= ST_RUN;
            cnt   <= 2'd0;
          end
        endcase
      end
    end
  end

  assign ex_mem_re    = ex_c.mem_re;
  assign ex_mem_we    = ex_c.mem_we;
  assign ex_reg_write = ex_c.reg_write;
  assign ex_branch    = ex_c.branch;
  assign ex_jump      = ex_c.jump;
  assign ex_illegal   = ex_c.illegal;
  assign ex_alu_op    = ex_c.alu_op;
  assign ex_sel_mux_1 = ex_c.mux1;
  assign ex_sel_mux_2 = ex_c.mux2;
  assign ex_sel_mux_4 = ex_c.mux4;
  assign state_dbg    = {state == ST_STALL, cnt};

endmodule

// File: tb/tb_pipe_controller.sv
// Random-stimulus bench for pipe_controller: two instances (1 and 3 load-use bubbles)
// each checked against a cycle-level reference model through an expected-value queue.
module tb_pipe_controller;

  localparam int N_CYC = 800;
  localparam int W     = 58;  // {stall, ex word, mem word, wb word}

  typedef struct packed {
    logic       v;
    logic [6:0] opc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } instr_t;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_s [2];
  logic       valid_s [2];
  logic       br_s    [2];
  logic [6:0] opc_s   [2];
  logic [4:0] rs1_s   [2];
  logic [4:0] rs2_s   [2];
  logic [4:0] rd_s    [2];

  logic       stall_o [2];
  logic       ex_mre_o[2], ex_mwe_o[2], ex_rw_o[2], ex_br_o[2], ex_j_o[2], ex_ill_o[2];
  logic [1:0] ex_alu_o[2], ex_m1_o[2], ex_m2_o[2], ex_m4_o[2];
  logic [4:0] ex_rd_o [2];
  logic       mem_mre_o[2], mem_mwe_o[2], mem_rw_o[2];
  logic [1:0] mem_m2_o[2];
  logic [4:0] mem_rd_o[2];
  logic       wb_rw_o [2];
  logic [1:0] wb_m2_o [2];
  logic [4:0] wb_rd_o [2];
  logic [2:0] dbg_o   [2];

  pipe_controller #(.LOAD_USE_BUBBLES(1)) dut_a (
    .clock(clock), .reset(reset_s[0]), .id_valid(valid_s[0]), .opcode(opc_s[0]),
    .rs1(rs1_s[0]), .rs2(rs2_s[0]), .rd(rd_s[0]), .branch_taken(br_s[0]),
    .stall(stall_o[0]), .ex_mem_re(ex_mre_o[0]), .ex_mem_we(ex_mwe_o[0]),
    .ex_reg_write(ex_rw_o[0]), .ex_branch(ex_br_o[0]), .ex_jump(ex_j_o[0]),
    .ex_illegal(ex_ill_o[0]), .ex_alu_op(ex_alu_o[0]), .ex_sel_mux_1(ex_m1_o[0]),
    .ex_sel_mux_2(ex_m2_o[0]), .ex_sel_mux_4(ex_m4_o[0]), .ex_rd(ex_rd_o[0]),
    .mem_mem_re(mem_mre_o[0]), .mem_mem_we(mem_mwe_o[0]), .mem_reg_write(mem_rw_o[0]),
    .mem_sel_mux_2(mem_m2_o[0]), .mem_rd(mem_rd_o[0]), .wb_reg_write(wb_rw_o[0]),
    .wb_sel_mux_2(wb_m2_o[0]), .wb_rd(wb_rd_o[0]), .state_dbg(dbg_o[0])
  );

  pipe_controller #(.LOAD_USE_BUBBLES(3)) dut_b (
    .clock(clock), .reset(reset_s[1]), .id_valid(valid_s[1]), .opcode(opc_s[1]),
    .rs1(rs1_s[1]), .rs2(rs2_s[1]), .rd(rd_s[1]), .branch_taken(br_s[1]),
    .stall(stall_o[1]), .ex_mem_re(ex_mre_o[1]), .ex_mem_we(ex_mwe_o[1]),
    .ex_reg_write(ex_rw_o[1]), .ex_branch(ex_br_o[1]), .ex_jump(ex_j_o[1]),
    .ex_illegal(ex_ill_o[1]), .ex_alu_op(ex_alu_o[1]), .ex_sel_mux_1(ex_m1_o[1]),
    .ex_sel_mux_2(ex_m2_o[1]), .ex_sel_mux_4(ex_m4_o[1]), .ex_rd(ex_rd_o[1]),
    .mem_mem_re(mem_mre_o[1]), .mem_mem_we(mem_mwe_o[1]), .mem_reg_write(mem_rw_o[1]),
    .mem_sel_mux_2(mem_m2_o[1]), .mem_rd(mem_rd_o[1]), .wb_reg_write(wb_rw_o[1]),
    .wb_sel_mux_2(wb_m2_o[1]), .wb_rd(wb_rd_o[1]), .state_dbg(dbg_o[1])
  );

  // reference model: control word layout
  // [18]mem_re [17]mem_we [16]reg_write [15]branch [14]jump [13]illegal
  // [12:11]alu_op [10:9]mux1 [8:7]mux2 [6:5]mux4 [4:0]rd
  function automatic logic [18:0] mk(input logic mr, input logic mw, input logic rw,
                                     input logic b, input logic j, input logic [1:0] alu,
                                     input logic [1:0] m1, input logic [1:0] m2,
                                     input logic [1:0] m4);
    return {mr, mw, rw, b, j, 1'b0, alu, m1, m2, m4, 5'd0};
  endfunction

  function automatic logic [18:0] ref_decode(input instr_t i, output logic u1, output logic u2);
    logic [18:0] w;
    logic        ok;
    w = '0; u1 = 1'b0; u2 = 1'b0; ok = 1'b1;
    case (i.opc)
      7'b0110011: begin w = mk(0, 0, 1, 0, 0, 2'b10, 2'd0, 2'd1, 2'd0); u1 = 1; u2 = 1; end
      7'b0010011: begin w = mk(0, 0, 1, 0, 0, 2'b11, 2'd1, 2'd1, 2'd0); u1 = 1; end
      7'b0000011: begin w = mk(1, 0, 1, 0, 0, 2'b01, 2'd1, 2'd0, 2'd0); u1 = 1; end
      7'b0100011: begin w = mk(0, 1, 0, 0, 0, 2'b00, 2'd1, 2'd0, 2'd1); u1 = 1; u2 = 1; end
      7'b1100011: begin w = mk(0, 0, 0, 1, 0, 2'b00, 2'd0, 2'd0, 2'd0); u1 = 1; u2 = 1; end
`ifdef CTRL_JUMP_EN
      7'b1101111: w = mk(0, 0, 1, 0, 1, 2'b00, 2'd0, 2'd2, 2'd0);
      7'b1100111: begin w = mk(0, 0, 1, 0, 1, 2'b00, 2'd1, 2'd2, 2'd0); u1 = 1; end
      7'b0110111: w = mk(0, 0, 1, 0, 0, 2'b00, 2'd0, 2'd3, 2'd0);
      7'b0010111: w = mk(0, 0, 1, 0, 0, 2'b00, 2'd1, 2'd1, 2'd2);
`endif
      default: ok = 1'b0;
    endcase
    if (!i.v) begin
      u1 = 1'b0; u2 = 1'b0;
      return '0;
    end
    if (!ok) return 19'h02000;
    w[4:0] = i.rd;
    if (i.rd == 5'd0) w[16] = 1'b0;
    return w;
  endfunction

  function automatic logic [9:0] mem_view(input logic [18:0] w);
    return {w[18], w[17], w[16], w[8:7], w[4:0]};
  endfunction

  function automatic logic [7:0] wb_view(input logic [18:0] w);
    return {w[16], w[8:7], w[4:0]};
  endfunction

  int          lub [2] = '{1, 3};
  logic [18:0] m_ex [2], m_mem [2], m_wb [2];
  int          stall_left [2];
  int          ptr [2];
  instr_t      prog[$];
  logic [W-1:0] exp_q0[$], exp_q1[$];
  int total = 0;
  int bad   = 0;

  // scoreboard compare
  task automatic check(input int k, input logic [W-1:0] e);
    logic [18:0] a_ex;
    logic [9:0]  a_mem;
    logic [7:0]  a_wb;
    a_ex  = {ex_mre_o[k], ex_mwe_o[k], ex_rw_o[k], ex_br_o[k], ex_j_o[k], ex_ill_o[k],
             ex_alu_o[k], ex_m1_o[k], ex_m2_o[k], ex_m4_o[k], ex_rd_o[k]};
    a_mem = {mem_mre_o[k], mem_mwe_o[k], mem_rw_o[k], mem_m2_o[k], mem_rd_o[k]};
    a_wb  = {wb_rw_o[k], wb_m2_o[k], wb_rd_o[k]};
    total += 4;
    if (stall_o[k] !== e[57]) begin
      bad++; $display("FAIL dut%0d stall @%0t: got %b want %b", k, $time, stall_o[k], e[57]);
    end
    if (a_ex !== e[56:38]) begin
      bad++; $display("FAIL dut%0d ex @%0t: got %h want %h", k, $time, a_ex, e[56:38]);
    end
    if (a_mem !== mem_view(e[37:19])) begin
      bad++; $display("FAIL dut%0d mem @%0t: got %h want %h", k, $time, a_mem, mem_view(e[37:19]));
    end
    if (a_wb !== wb_view(e[18:0])) begin
      bad++; $display("FAIL dut%0d wb @%0t: got %h want %h", k, $time, a_wb, wb_view(e[18:0]));
    end
  endtask

  // monitor: compares whatever the driver predicted for this cycle
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (exp_q0.size() > 0) check(0, exp_q0.pop_front());
      if (exp_q1.size() > 0) check(1, exp_q1.pop_front());
    end
  end

  // driver task: apply one cycle of inputs to dut k and advance its model
  task automatic step(input int k, input int cyc);
    logic        rst, br, st, u1, u2, hz;
    logic [18:0] d, nxt;
    instr_t      ins;
    rst = (cyc < 2) || ($urandom_range(0, 99) < 2);
    br  = !rst && ($urandom_range(0, 99) < 8);
    ins = prog[ptr[k]];
    reset_s[k] = rst; br_s[k] = br; valid_s[k] = ins.v; opc_s[k] = ins.opc;
    rs1_s[k] = ins.rs1; rs2_s[k] = ins.rs2; rd_s[k] = ins.rd;

    d  = ref_decode(ins, u1, u2);
    hz = (lub[k] > 0) && ins.v && m_ex[k][18] && (m_ex[k][4:0] != 0) &&
         ((u1 && ins.rs1 == m_ex[k][4:0]) || (u2 && ins.rs2 == m_ex[k][4:0]));
    nxt = '0;
    st  = 1'b0;
    if (rst) stall_left[k] = 0;
    else if (br) stall_left[k] = 0;
    else if (stall_left[k] > 0) begin st = 1'b1; stall_left[k]--; end
    else if (hz) begin st = 1'b1; stall_left[k] = lub[k] - 1; end
    else nxt = d;

    if (k == 0) exp_q0.push_back({st, m_ex[k], m_mem[k], m_wb[k]});
    else        exp_q1.push_back({st, m_ex[k], m_mem[k], m_wb[k]});

    if (rst) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
    end else begin
      m_wb[k] = m_mem[k]; m_mem[k] = m_ex[k]; m_ex[k] = nxt;
    end
    if (!st) ptr[k]++;
  endtask

  initial begin
    logic [6:0] opc_tab [12];
    instr_t     t;
    opc_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0000011};
    // directed prefix, then random traffic over a small register set to provoke hazards
    prog.push_back('{1'b1, 7'b0110011, 5'd1, 5'd2, 5'd5});
    prog.push_back('{1'b1, 7'b0000011, 5'd1, 5'd0, 5'd3});
    prog.push_back('{1'b1, 7'b0110011, 5'd3, 5'd2, 5'd4});
    prog.push_back('{1'b1, 7'b0000011, 5'd4, 5'd0, 5'd2});
    prog.push_back('{1'b1, 7'b0000011, 5'd2, 5'd0, 5'd1});
    prog.push_back('{1'b1, 7'b0100011, 5'd3, 5'd1, 5'd0});
    prog.push_back('{1'b1, 7'b1111111, 5'd1, 5'd1, 5'd1});
    prog.push_back('{1'b1, 7'b0110011, 5'd1, 5'd2, 5'd0});
    prog.push_back('{1'b1, 7'b1101111, 5'd0, 5'd0, 5'd1});
    for (int i = 0; i < N_CYC + 10; i++) begin
      t.v   = ($urandom_range(0, 9) != 0);
      t.opc = opc_tab[$urandom_range(0, 11)];
      t.rs1 = 5'($urandom_range(0, 3));
      t.rs2 = 5'($urandom_range(0, 3));
      t.rd  = 5'($urandom_range(0, 3));
      prog.push_back(t);
    end
    for (int k = 0; k < 2; k++) begin
      reset_s[k] = 1'b1; br_s[k] = 1'b0; valid_s[k] = 1'b0; opc_s[k] = '0;
      rs1_s[k] = '0; rs2_s[k] = '0; rd_s[k] = '0;
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; stall_left[k] = 0; ptr[k] = 0;
    end
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clock);
      step(0, cyc);
      step(1, cyc);
    end
    @(negedge clock);
    #5;
    total++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d pending want 0", exp_q0.size(), exp_q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
